pic_nch: RTL and testbench
==========================

PIC_NCH -- requirements
Module: pic_nch

Interface
REQ-001 Parameter NCH, default 8, number of interrupt channels; legal range 2..32.
REQ-002 Parameter VW, default 3, vector width; SHALL equal ceil(log2(NCH)), with minimum 1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sel  input  2  register select: 0=CTRL, 1=IMR, 2=IRR, 3=ISR.
REQ-006 wr  input  1  write strobe; a write occurs on each clk edge where wr=1.
REQ-007 wdata  input  NCH  write data.
REQ-008 rdata  output  NCH  combinational read of the register chosen by sel; CTRL reads as {zero-extend, edge, en}.
REQ-009 intreq  input  NCH  interrupt request lines, synchronous to clk.
REQ-010 intack  input  1  single-cycle acknowledge pulse from the CPU.
REQ-011 int  output  1  registered interrupt request to the CPU.
REQ-012 vec  output  VW  index of the channel acknowledged; valid only while vec_valid=1.
REQ-013 vec_valid  output  1  one-cycle pulse, registered, in the cycle after an accepted intack.

Function
REQ-014 CTRL bit0 en is the global enable. CTRL bit1 edge selects edge mode (1) or level mode (0). Writes to CTRL update only these two bits.
REQ-015 IMR write loads wdata; bit=1 masks the channel; IMR does not affect IRR capture.
REQ-016 Edge mode: IRR[i] sets on an intreq[i] 0->1 transition, detected against a registered copy of intreq (one cycle of capture latency).
REQ-017 Level mode: IRR[i] sets in any cycle where intreq[i]=1.
REQ-018 IRR write is write-1-to-clear. When a clear and a set of the same bit happen in the same cycle, the set wins.
REQ-019 ISR write is write-1-to-clear and acts as EOI. A write of all-zero has no effect.
REQ-020 pend = IRR & ~IMR. The winner is the highest-priority pend bit; with fixed priority, channel 0 is highest.
REQ-021 int shall be 1 in the cycle after en=1, pend!=0, and the winner's priority is strictly above every ISR bit (nested service); otherwise int=0.
REQ-022 intack with int=1: on that edge, clear IRR[winner], set ISR[winner], and register vec=winner and vec_valid=1. int drops to 0 on the following cycle unless a higher-priority request qualifies.
REQ-023 intack with int=0 is ignored: no state change, and vec_valid stays 0.
REQ-024 In edge mode, if a new edge arrives on the winner channel in the same cycle as intack, IRR stays 1 (set wins) and ISR is still set.
REQ-025 en=0 forces int=0 and blocks intack, but IRR capture continues.
REQ-026 If a register write and an intack hit the same ISR or IRR bit in the same cycle, the intack update is applied after the write.

Reset
REQ-027 On reset=1 at a clk edge, the block shall load CTRL=0, IMR=all-ones, IRR=0, ISR=0, the intreq history register=0, int=0, vec=0, vec_valid=0.
REQ-028 Reset mid-service discards all pending and in-service state. No vec_valid pulse follows, and reset overrides wr and intack in the same cycle.

Configuration
REQ-029 Macro PIC_ROTATE_EN: when defined, the block uses rotating priority. A priority pointer (reset 0) names the highest channel; on each EOI of channel k, the pointer becomes (k+1) mod NCH.
REQ-030 When PIC_ROTATE_EN is defined and one ISR write clears several bits, the pointer rotates past the highest-numbered cleared channel.
REQ-031 Without PIC_ROTATE_EN, priority is fixed with channel 0 highest, and no pointer logic is instantiated.

Verification
REQ-032 Reset, read all registers -> CTRL=0, IMR=0xFF, IRR=0, ISR=0, int=0.
REQ-033 CTRL=0x03, IMR=0x00, pulse intreq[5] then intreq[2] -> IRR=0x24; int=1; intack -> vec=2, vec_valid=1, ISR=0x04, IRR=0x20.
REQ-034 With ISR=0x04, hold intreq[5] pending -> int=0; raise intreq[1] -> int=1 (nest); EOI write ISR=0x04 with IRR bit5 still pending -> int=1 after bit1 is serviced.
REQ-035 Level mode, IMR=0xFE, intreq[0] held high through intack -> ISR=0x01 and IRR re-sets to 0x01 on the next cycle.
REQ-036 intack with int=0 -> all registers unchanged, vec_valid=0. Reset asserted the same cycle as intack -> all registers at reset values.
REQ-037 PIC_ROTATE_EN build, service and EOI channel 3, then pend channels 0 and 4 -> vec=4.

Source files
------------

// File: rtl/pic_nch_if.sv
// pic_nch_if: register and interrupt bus between a CPU-side master and the pic_nch controller.
//   sel/wr/wdata/rdata : register access (0=CTRL, 1=IMR, 2=IRR, 3=ISR)
//   intreq             : interrupt request lines, synchronous to clk
//   intack             : single-cycle acknowledge from the CPU
//   intr               : registered interrupt request to the CPU
//   vec/vec_valid      : acknowledged channel index and its one-cycle qualifier
interface pic_nch_if #(
    parameter int NCH = 8,
    parameter int VW  = 3
);
    logic [1:0]     sel;
    logic           wr;
    logic [NCH-1:0] wdata;
    logic [NCH-1:0] rdata;
    logic [NCH-1:0] intreq;
    logic           intack;
    logic           intr;
    logic [VW-1:0]  vec;
    logic           vec_valid;

    modport master (output sel, wr, wdata, intreq, intack, input rdata, intr, vec, vec_valid);
    modport slave  (input sel, wr, wdata, intreq, intack, output rdata, intr, vec, vec_valid);
endinterface

// File: rtl/pic_nch.sv
// pic_nch: NCH-channel programmable interrupt controller with nested in-service priority.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pic_nch_if slave (register access, intreq/intack, intr, vec/vec_valid)
// Define PIC_ROTATE_EN for rotating priority; otherwise channel 0 is always highest.
module pic_nch #(
    parameter int NCH = 8,
    parameter int VW  = 3
) (
    input logic      clk,
    input logic      reset,
    pic_nch_if.slave bus
);
    localparam logic [VW:0] RMAX = (VW+1)'(NCH);

    logic           en, edge_mode;
    logic [NCH-1:0] imr, irr, isr, req_q, pend, set, irr_clr, isr_clr, ack_bit;
    logic [VW-1:0]  win;
    logic [VW:0]    win_rank, isr_rank;
    logic           qualify, ack;
    logic [VW-1:0]  order [NCH];

`ifdef PIC_ROTATE_EN
    logic [VW-1:0]  ptr, ptr_nxt;
    logic [NCH-1:0] eoi;

    // order[r] is the channel holding priority rank r, starting from the pointer
    for (genvar i = 0; i < NCH; i++) begin : g_ord
        logic [VW:0] s;
        assign s = {1'b0, ptr} + (VW+1)'(i);
        assign order[i] = (s >= RMAX) ? VW'(s - RMAX) : VW'(s);
    end

    // only bits actually in service count as an EOI for rotation
    assign eoi = isr_clr & isr;

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < NCH; i++)
            if (eoi[i]) ptr_nxt = (i == NCH - 1) ? '0 : VW'(i + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else       ptr <= ptr_nxt;
    end
`else
    for (genvar i = 0; i < NCH; i++) begin : g_ord
        assign order[i] = VW'(i);
    end
`endif

    assign pend = irr & ~imr;

    // lowest rank wins; isr_rank is the rank of the highest-priority channel in service
    always_comb begin
        win      = '0;
        win_rank = RMAX;
        isr_rank = RMAX;
        for (int r = NCH - 1; r >= 0; r--) begin
            if (pend[order[r]]) begin
                win      = order[r];
                win_rank = (VW+1)'(r);
            end
            if (isr[order[r]]) isr_rank = (VW+1)'(r);
        end
    end

    assign qualify = en & (|pend) & (win_rank < isr_rank);
    // re-qualify at the ack edge so a stale intr cannot accept a now-blocked channel
    assign ack     = bus.intack & bus.intr & qualify;
    assign set     = edge_mode ? (bus.intreq & ~req_q) : bus.intreq;
    assign irr_clr = (bus.wr && bus.sel == 2'd2) ? bus.wdata : '0;
    assign isr_clr = (bus.wr && bus.sel == 2'd3) ? bus.wdata : '0;
    assign ack_bit = ack ? (NCH'(1) << win) : '0;

    assign bus.rdata = (bus.sel == 2'd0) ? NCH'({edge_mode, en}) :
                       (bus.sel == 2'd1) ? imr :
                       (bus.sel == 2'd2) ? irr : isr;

    always_ff @(posedge clk) begin
        if (reset) begin
            en            <= 1'b0;
            edge_mode     <= 1'b0;
            imr           <= '1;
            irr           <= '0;
            isr           <= '0;
            req_q         <= '0;
            bus.intr      <= 1'b0;
            bus.vec       <= '0;
            bus.vec_valid <= 1'b0;
        end else begin
            if (bus.wr && bus.sel == 2'd0) {edge_mode, en} <= bus.wdata[1:0];
            if (bus.wr && bus.sel == 2'd1) imr <= bus.wdata;
            // write clear first, then ack clear; a new request always wins
            irr           <= (irr & ~irr_clr & ~ack_bit) | set;
            isr           <= (isr & ~isr_clr) | ack_bit;
            req_q         <= bus.intreq;
            bus.intr      <= qualify;
            bus.vec_valid <= ack;
            if (ack) bus.vec <= win;
        end
    end
endmodule

// File: tb/tb_pic_nch.sv
// tb_pic_nch: directed table, rotation sequence and randomized model comparison for pic_nch.
module tb_pic_nch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pic_nch_if #(.NCH(8), .VW(3)) bus ();
    pic_nch #(.NCH(8), .VW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] req;
        logic       ack;
        logic [1:0] rsel;
        logic [7:0] rexp;
        logic       iexp;
        logic       vvexp;
        logic [2:0] vexp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] s, logic w, logic [7:0] d, logic [7:0] q,
                                logic a, logic [1:0] rs, logic [7:0] re, logic ie, logic ve,
                                logic [2:0] vx);
        vec_t t;
        t.rst = r; t.sel = s; t.wr = w; t.wdata = d; t.req = q; t.ack = a;
        t.rsel = rs; t.rexp = re; t.iexp = ie; t.vvexp = ve; t.vexp = vx;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [1:0] s, logic w, logic [7:0] d, logic [7:0] q, logic a);
        @(negedge clk);
        reset = r; bus.sel = s; bus.wr = w; bus.wdata = d; bus.intreq = q; bus.intack = a;
        @(posedge clk);
        #1;
        reset = 1'b0; bus.wr = 1'b0; bus.intack = 1'b0;
    endtask

    // behavioural model: priority is a rank relative to the rotation pointer
    logic       m_en, m_edge, m_intr, m_vv;
    logic [7:0] m_imr, m_irr, m_isr, m_prev;
    logic [2:0] m_vec;
    int         m_ptr;

    function automatic int rank(int c);
        return (c - m_ptr + 8) % 8;
    endfunction

    function automatic logic [7:0] model_read(logic [1:0] s);
        return s == 2'd0 ? {6'b0, m_edge, m_en} : s == 2'd1 ? m_imr : s == 2'd2 ? m_irr : m_isr;
    endfunction

    task automatic model_step(logic r, logic [1:0] s, logic w, logic [7:0] d, logic [7:0] q, logic a);
        int win, best;
        logic qual, acc;
        logic [7:0] nirr, nisr, setv;
        if (r) begin
            m_en = 0; m_edge = 0; m_imr = 8'hFF; m_irr = 0; m_isr = 0; m_prev = 0;
            m_intr = 0; m_vv = 0; m_vec = 0; m_ptr = 0;
            return;
        end
        win = -1;
        best = 8;
        for (int c = 0; c < 8; c++) begin
            if (m_irr[c] && !m_imr[c] && (win < 0 || rank(c) < rank(win))) win = c;
            if (m_isr[c] && rank(c) < best) best = rank(c);
        end
        qual = m_en && win >= 0 && rank(win) < best;
        acc  = a && m_intr && qual;
        setv = m_edge ? (q & ~m_prev) : q;
        nirr = m_irr;
        nisr = m_isr;
        if (w && s == 2'd2) nirr = nirr & ~d;
        if (w && s == 2'd3) begin
`ifdef PIC_ROTATE_EN
            for (int c = 0; c < 8; c++)
                if (d[c] && m_isr[c]) m_ptr = (c + 1) % 8;
`endif
            nisr = nisr & ~d;
        end
        if (acc) begin
            nirr[win] = 1'b0;
            nisr[win] = 1'b1;
            m_vec = 3'(win);
        end
        m_irr = nirr | setv;
        m_isr = nisr;
        if (w && s == 2'd0) {m_edge, m_en} = d[1:0];
        if (w && s == 2'd1) m_imr = d;
        m_intr = qual;
        m_vv   = acc;
        m_prev = q;
    endtask

    initial begin
        logic [7:0] d;
        logic       r;
        bus.sel = 0; bus.wr = 0; bus.wdata = 0; bus.intreq = 0; bus.intack = 0;

        //             rst sel wr wdata  req    ack rsel rexp   int vv vec
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 3, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h03, 8'h00, 0, 0, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h20, 0, 2, 8'h20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h04, 0, 2, 8'h24, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h24, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 3, 8'h04, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 3, 8'h04, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h02, 0, 2, 8'h22, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h22, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 3, 8'h06, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h20, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 8'h04, 8'h00, 0, 3, 8'h02, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 8'h02, 8'h00, 0, 3, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 3, 8'h20, 1, 1, 5));
        tbl.push_back(mk(0, 3, 1, 8'h20, 8'h00, 0, 3, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h01, 8'h00, 0, 0, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hFE, 8'h00, 0, 1, 8'hFE, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 2, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 2, 8'h01, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h01, 1, 3, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h01, 0, 2, 8'h01, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'h00, 8'h00, 1, 3, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0));

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].sel, tbl[k].wr, tbl[k].wdata, tbl[k].req, tbl[k].ack);
            bus.sel = tbl[k].rsel;
            #1;
            chk($sformatf("step%0d rdata", k), bus.rdata, tbl[k].rexp);
            chk($sformatf("step%0d intr", k), bus.intr, tbl[k].iexp);
            chk($sformatf("step%0d vec_valid", k), bus.vec_valid, tbl[k].vvexp);
            if (tbl[k].vvexp) chk($sformatf("step%0d vec", k), bus.vec, tbl[k].vexp);
        end

`ifdef PIC_ROTATE_EN
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        drive(0, 0, 1, 8'h03, 8'h00, 0);
        drive(0, 1, 1, 8'h00, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 8'h08, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        chk("rot intr ch3", bus.intr, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 1);
        chk("rot vv ch3", bus.vec_valid, 1);
        chk("rot vec ch3", bus.vec, 3);
        drive(0, 3, 1, 8'h08, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 8'h11, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        chk("rot intr ch4", bus.intr, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 1);
        chk("rot vv ch4", bus.vec_valid, 1);
        chk("rot vec ch4", bus.vec, 4);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = (i == 0) || ($urandom_range(199) == 0);
            reset = r;
            bus.sel = 2'($urandom_range(3));
            bus.wr = ($urandom_range(3) == 0);
            d = 8'($urandom);
            if (bus.sel == 2'd0) d[0] = ($urandom_range(6) != 0);
            if (bus.sel == 2'd1) d = d & 8'($urandom);
            bus.wdata = d;
            bus.intreq = 8'($urandom & $urandom & $urandom);
            bus.intack = ($urandom_range(2) == 0);
            #1;
            if (i > 0) begin
                chk("rnd rdata", bus.rdata, model_read(bus.sel));
                chk("rnd intr", bus.intr, m_intr);
                chk("rnd vec_valid", bus.vec_valid, m_vv);
                if (m_vv) chk("rnd vec", bus.vec, m_vec);
            end
            model_step(r, bus.sel, bus.wr, bus.wdata, bus.intreq, bus.intack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
